// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and load clamp helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_updown_cell.sv
// rtl/bcd_updown_cell.sv - one up/down BCD decade with terminal-count flags.
module bcd_updown_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_in,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t value,
  output bcd_digit_t digit,
  output logic       term_up,
  output logic       term_down
);

  assign term_up   = (digit == BCD_MAX);
  assign term_down = (digit == BCD_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= value;
    end else if (en_in) begin
      if (up) digit <= term_up ? BCD_MIN : digit + 4'd1;
      else    digit <= term_down ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - N-decade up/down BCD counter with wrap pulses.
// Parallel load with digit clamping is built only when BCD_COUNTER_LOAD_EN is defined.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry_out,
  output logic                    borrow_out,
  output logic                    load_err
);

  logic                    load_int;
  logic [4*NUM_DIGITS-1:0] load_clamped;
  logic [NUM_DIGITS:0]     en_chain;
  logic [NUM_DIGITS-1:0]   term_up;
  logic [NUM_DIGITS-1:0]   term_down;

`ifdef BCD_COUNTER_LOAD_EN
  logic load_over;

  assign load_int = load;

  always_comb begin
    load_clamped = '0;
    load_over    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      load_clamped[4*k +: 4] = bcd_clamp(load_value[4*k +: 4]);
      if (load_value[4*k +: 4] > BCD_MAX) load_over = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) load_err <= 1'b0;
    else       load_err <= load & load_over;
  end
`else
  logic unused_load;

  assign load_int     = 1'b0;
  assign load_clamped = '0;
  assign load_err     = 1'b0;
  assign unused_load  = ^{load, load_value};
`endif

  // A decade steps only when every lower decade sits at its terminal value.
  assign en_chain[0] = en;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_updown_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .en_in     (en_chain[k]),
      .up        (up),
      .load      (load_int),
      .value     (load_clamped[4*k +: 4]),
      .digit     (count[4*k +: 4]),
      .term_up   (term_up[k]),
      .term_down (term_down[k])
    );
    assign en_chain[k+1] = en_chain[k] & (up ? term_up[k] : term_down[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      carry_out  <= ~load_int & en_chain[NUM_DIGITS] & up;
      borrow_out <= ~load_int & en_chain[NUM_DIGITS] & ~up;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - randomized bench for bcd_counter_n against an integer model.
module tb_bcd_counter_n;

  localparam int N   = 4;
  localparam int MOD = 10000;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          up;
  logic          load;
  logic [4*N-1:0] load_value;
  logic [4*N-1:0] count;
  logic          carry_out;
  logic          borrow_out;
  logic          load_err;

  int n_checks = 0;
  int n_fail   = 0;

  int m_val;
  bit m_carry, m_borrow, m_err;

  bcd_counter_n #(.NUM_DIGITS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .carry_out  (carry_out),
    .borrow_out (borrow_out),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic e, input logic u, input logic l, input logic [4*N-1:0] lv);
    int v, p, d;
    m_carry  = 1'b0;
    m_borrow = 1'b0;
    m_err    = 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
    if (l) begin
      v = 0;
      p = 1;
      for (int k = 0; k < N; k++) begin
        d = int'(lv[4*k +: 4]);
        if (d > 9) begin
          d = 9;
          m_err = 1'b1;
        end
        v += d * p;
        p *= 10;
      end
      m_val = v;
      return;
    end
`endif
    if (e) begin
      if (u) begin
        m_val   = (m_val + 1) % MOD;
        m_carry = (m_val == 0);
      end else if (m_val == 0) begin
        m_val    = MOD - 1;
        m_borrow = 1'b1;
      end else begin
        m_val = m_val - 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".count"},  32'(count),      32'(to_bcd(m_val)));
    check_eq({tag, ".carry"},  32'(carry_out),  32'(m_carry));
    check_eq({tag, ".borrow"}, 32'(borrow_out), 32'(m_borrow));
    check_eq({tag, ".lerr"},   32'(load_err),   32'(m_err));
  endtask

  task automatic cycle(input string tag, input logic e, input logic u, input logic l, input logic [4*N-1:0] lv);
    en = e;
    up = u;
    load = l;
    load_value = lv;
    @(posedge clk);
    model_step(e, u, l, lv);
    #1;
    check_outputs(tag);
  endtask

  task automatic go_to(input int target);
    int diff;
`ifdef BCD_COUNTER_LOAD_EN
    cycle("goto_load", 1'b0, 1'b0, 1'b1, to_bcd(target));
`else
    diff = (target - m_val + MOD) % MOD;
    if (diff <= MOD / 2) begin
      for (int i = 0; i < diff; i++) cycle("goto_up", 1'b1, 1'b1, 1'b0, '0);
    end else begin
      for (int i = 0; i < MOD - diff; i++) cycle("goto_dn", 1'b1, 1'b0, 1'b0, '0);
    end
`endif
    check_eq("goto_reached", 32'(count), 32'(to_bcd(target)));
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_val = 0; m_carry = 0; m_borrow = 0; m_err = 0;
    check_outputs({tag, "_async"});
    en = 1'b1; up = 1'b1; load = 1'b1; load_value = 16'h5555;
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    #2;
    reset = 1'b0;
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; up = 1'b0; load = 1'b0; load_value = '0;
    m_val = 0; m_carry = 0; m_borrow = 0; m_err = 0;
    #12;
    check_outputs("por");
    reset = 1'b0;

    go_to(457);
    pulse_reset("rst_mid");

    go_to(9998);
    cycle("upwrap1", 1'b1, 1'b1, 1'b0, '0);
    check_eq("upwrap1_val", 32'(count), 32'h9999);
    cycle("upwrap2", 1'b1, 1'b1, 1'b0, '0);
    check_eq("upwrap2_val", 32'(count), 32'h0000);
    check_eq("upwrap2_cy", 32'(carry_out), 32'd1);
    cycle("after_wrap", 1'b0, 1'b1, 1'b0, '0);
    check_eq("carry_drop", 32'(carry_out), 32'd0);

    go_to(1);
    cycle("dnwrap1", 1'b1, 1'b0, 1'b0, '0);
    check_eq("dnwrap1_val", 32'(count), 32'h0000);
    cycle("dnwrap2", 1'b1, 1'b0, 1'b0, '0);
    check_eq("dnwrap2_val", 32'(count), 32'h9999);
    check_eq("dnwrap2_bw", 32'(borrow_out), 32'd1);
    pulse_reset("rst_pulse");

    go_to(199);
    cycle("ripple_up", 1'b1, 1'b1, 1'b0, '0);
    check_eq("ripple_up_val", 32'(count), 32'h0200);
    cycle("dir_dn1", 1'b1, 1'b0, 1'b0, '0);
    check_eq("dir_dn1_val", 32'(count), 32'h0199);
    cycle("dir_dn2", 1'b1, 1'b0, 1'b0, '0);
    check_eq("dir_dn2_val", 32'(count), 32'h0198);

    cycle("load_clamp", 1'b1, 1'b1, 1'b1, 16'h3A7F);
`ifdef BCD_COUNTER_LOAD_EN
    check_eq("load_clamp_val", 32'(count), 32'h3979);
    check_eq("load_clamp_err", 32'(load_err), 32'd1);
`else
    check_eq("load_ign_val", 32'(count), 32'h0199);
    check_eq("load_ign_err", 32'(load_err), 32'd0);
`endif
    cycle("load_after", 1'b0, 1'b0, 1'b0, '0);
    check_eq("lerr_drop", 32'(load_err), 32'd0);
    cycle("load_no_en", 1'b0, 1'b0, 1'b1, 16'hFFFF);

    for (int i = 0; i < 10; i++) cycle("hold", 1'b0, 1'(i & 1), 1'b0, 16'(i));

    for (int i = 0; i < 400; i++) begin
      logic [4*N-1:0] lv;
      lv = 16'($urandom);
      cycle("rand", ($urandom_range(0, 9) < 7), 1'($urandom),
            ($urandom_range(0, 9) == 0), lv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
